data_rx: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/data_rx_timeout.sv | 35 +++
 rtl/data_rx.sv | 90 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART link definitions: key encoding offset, byte type and
// receive FSM state type used by both ends of the keypad link.
package uart_pkg;

    localparam int KEY_OFFSET = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/data_rx_timeout.sv
// Idle counter with sticky stale flag; cleared by each received byte.
// Only instantiated when DATA_RX_TIMEOUT_EN is defined.
module data_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_stale
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;
    logic         r_stale;

    // i_clr leads the rx_valid pulse by one cycle so both clear on that edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_stale <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stale = r_stale;

endmodule

// File: rtl/data_rx.sv
// Receive side of the keypad link: pops the UART rx FIFO, removes the
// key offset and presents hex nibbles. Optional stale flag: DATA_RX_TIMEOUT_EN.
module data_rx
    import uart_pkg::*;
#(
    parameter int          KEY_OFFSET     = uart_pkg::KEY_OFFSET,
    parameter int          CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_empty,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    output logic [3:0]       hex1_data,
    output logic [3:0]       hex0_data,
    output logic             rx_valid,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             stale
);

    rx_state_t        r_state;
    byte_t            r_dec;
    logic [3:0]       r_hex1;
    logic [3:0]       r_hex0;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    byte_t w_dec;
    logic  w_pop;

    assign w_dec = r_data - byte_t'(KEY_OFFSET);
    assign w_pop = (r_state == POP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dec   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!rx_empty) begin
                        r_dec   <= w_dec;
                        r_state <= POP;
                    end
                end
                POP:     r_state <= SETTLE;
                // dead cycle lets the FIFO flag and head data catch up
                SETTLE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex1  <= '0;
            r_hex0  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_hex1 <= r_dec[7:4];
                r_hex0 <= r_dec[3:0];
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign rd_uart   = w_pop;
    assign hex1_data = r_hex1;
    assign hex0_data = r_hex0;
    assign rx_valid  = r_valid;
    assign byte_cnt  = r_cnt;

`ifdef DATA_RX_TIMEOUT_EN
    data_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_pop),
        .o_stale(stale)
    );
`else
    assign stale = 1'b0;
`endif

endmodule
